sp_ram_arbiter: RTL
===================

# sp_ram_arbiter

Two-port round-robin arbiter and sequencer for the single-port `sp_ram` block. After reset it sweeps every RAM word to `INIT_VALUE`, then shares the one RAM port between two requesters at up to one access per cycle, and returns read data with a per-requester valid. It sits between the two client blocks and the RAM instance; nothing else drives the RAM port.

## Interface
Parameters:
- `DATA_WIDTH`, 8, RAM word width.
- `ADDR_WIDTH`, 5, RAM address width; depth N = 2**ADDR_WIDTH.
- `INIT_VALUE`, 0, value written to every word during the init sweep.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: access request.
- `we0` / `we1` in 1: 1 = write, 0 = read; valid while `req` is high.
- `addr0` / `addr1` in ADDR_WIDTH: access address.
- `wdata0` / `wdata1` in DATA_WIDTH: write data.
- `gnt0` / `gnt1` out 1: combinational accept; the access completes in the cycle where `req & gnt` are both high.
- `rvalid0` / `rvalid1` out 1: `rdata` holds that requester's read result this cycle.
- `rdata` out DATA_WIDTH: shared read data, driven straight from `ram_q`. Meaningful only while an `rvalid` is high; may be Z otherwise.
- `init_done` out 1: sweep complete, arbitration active.
- `ram_en`, `ram_wen` out 1: registered RAM enable and write enable.
- `ram_addr` out ADDR_WIDTH: registered RAM address.
- `ram_din` out DATA_WIDTH: registered RAM write data.
- `ram_q` in DATA_WIDTH: RAM read data, 1-cycle registered latency.

## Operation
- FSM states are INIT and RUN. Reset enters INIT with the address counter at 0.
- **INIT**
  - Each edge issues `ram_en=1`, `ram_wen=1`, `ram_addr=cnt`, `ram_din=INIT_VALUE`, then increments `cnt`.
  - On the edge after the N-th write is issued: go to RUN, set `init_done=1`, drop `ram_en`.
  - `gnt0` and `gnt1` stay 0 in INIT; any requests are held off.
- **RUN arbitration**, using a `last` pointer:
  - Only one requester asserted: it is granted.
  - Both asserted: grant the requester that is not `last`.
  - Neither asserted: no grant.
  - `last` updates on every grant. Reset value `last=1`, so requester 0 wins the first tie.
- **Issue:** on the edge closing a grant cycle, the winner's `we`, `addr` and `wdata` are registered onto `ram_wen`, `ram_addr` and `ram_din` with `ram_en=1`. With no grant, `ram_en=0`.
- **Read tagging:** each read grant pushes a requester tag through a 2-stage valid pipeline, which drives `rvalid0` / `rvalid1`. Writes produce no response.
- Back-to-back grants are allowed every cycle, to either requester, in any read/write mix.
- Ordering: accesses reach the RAM in grant order. A read granted the cycle after a write to the same address returns the new data.

## Timing
- **Reset values:** `ram_en=0`, `ram_wen=0`, `ram_addr=0`, `ram_din=0`, `init_done=0`, `rvalid0=rvalid1=0`, `gnt0=gnt1=0`, `last=1`, state INIT, `cnt=0`.
- **Init sweep**, counting edges after `rst` falls:
  - Edge k (k = 1..N) issues the write to address k-1.
  - Edge N+1 sets `init_done` and drops `ram_en`.
  - The earliest grant is in the cycle after edge N+1.
- **Access latency**, with the grant in cycle T:
  - RAM command is visible in cycle T+1.
  - RAM commits or reads at the edge ending T+1.
  - For reads, `rvalid` and `rdata` are valid in cycle T+2.
- Throughput: one access per cycle, shared between both requesters.
- **Reset mid-operation:** asynchronous assertion immediately clears all registered outputs and the valid pipeline.
  - In-flight reads are dropped and never produce `rvalid`.
  - The init sweep restarts from address 0.
  - RAM contents present before the reset are overwritten by the new sweep.
- `cnt` wraps from N-1 to 0 only at sweep end; it is unused in RUN.

## Test plan
- **Init sweep:** release `rst` with N=32, no requests -> 32 consecutive writes to addresses 0..31 with data 0x00; `init_done` rises at edge 33; `gnt` stays 0 throughout.
- **Single-requester write/read:** req0 writes 0xA5 to address 3, then reads address 3 in the next cycle -> `rvalid0` 2 cycles after the read grant with `rdata=0xA5`; `rvalid1` stays 0.
- **Contention:** req0 and req1 held high for 4 cycles, reading addresses 1 and 2 (preloaded 0x11, 0x22) -> grants alternate 0,1,0,1; `rvalid0` and `rvalid1` alternate with data 0x11, 0x22, 0x11, 0x22.
- **Ordering:** req1 writes 0x5C to address 7 and req0 reads address 7 in the next cycle -> req0 gets 0x5C.
- **Requests during init:** req0 held high from reset release -> no `gnt0` before `init_done`; first `gnt0` in the cycle after edge 33.
- **Reset mid-read:** assert `rst` between a read grant and its `rvalid` -> no `rvalid`, all outputs at reset values immediately, and the full sweep reruns after release.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// Round-robin arbiter between two clients sharing one single-port RAM.
// It clears the RAM after reset, then grants at most one access per cycle and tags read returns.
module sp_ram_arbiter #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  init_done,
  output logic                  ram_en,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  last_q, last_d;
  logic                  ram_en_q, ram_en_d;
  logic                  ram_wen_q, ram_wen_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
  logic                  init_done_q, init_done_d;
  logic [1:0]            rd_vld_q, rd_vld_d;
  logic [1:0]            rd_tag_q, rd_tag_d;
  logic                  run;
  logic                  sel_we;

  // last_q names the most recent winner; the other side wins a tie.
  assign run  = (state_q == ST_RUN);
  assign gnt0 = run & req0 & (~req1 | last_q);
  assign gnt1 = run & req1 & (~req0 | ~last_q);
  assign sel_we = gnt1 ? we1 : we0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    ram_en_d    = 1'b0;
    ram_wen_d   = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    init_done_d = init_done_q;
    rd_vld_d    = {rd_vld_q[0], 1'b0};
    rd_tag_d    = {rd_tag_q[0], 1'b0};
    case (state_q)
      ST_INIT: begin
        // cnt back at 0 with a write already issued means the counter wrapped: sweep done.
        if (ram_en_q && cnt_q == '0) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          ram_en_d   = 1'b1;
          ram_wen_d  = 1'b1;
          ram_addr_d = cnt_q;
          ram_din_d  = INIT_VALUE;
          cnt_d      = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (gnt0 || gnt1) begin
          ram_en_d    = 1'b1;
          ram_wen_d   = sel_we;
          ram_addr_d  = gnt1 ? addr1 : addr0;
          ram_din_d   = gnt1 ? wdata1 : wdata0;
          last_d      = gnt1;
          rd_vld_d[0] = ~sel_we;
          rd_tag_d[0] = gnt1;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      ram_en_q    <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      init_done_q <= 1'b0;
      rd_vld_q    <= '0;
      rd_tag_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      ram_en_q    <= ram_en_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      init_done_q <= init_done_d;
      rd_vld_q    <= rd_vld_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_wen   = ram_wen_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign init_done = init_done_q;
  assign rvalid0   = rd_vld_q[1] & ~rd_tag_q[1];
  assign rvalid1   = rd_vld_q[1] &  rd_tag_q[1];
  assign rdata     = ram_q;

endmodule
